// File: rtl/stream_pattern_checker.sv
// Valid/ready stream sink: drains num_words with a rotating ready pattern, checks data against counter/LFSR.
// Ready is a pure function of flops (no path from i_tvalid); done pulses the cycle after the last accept.
module stream_pattern_checker #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] LFSR_TAPS = 32'h8020_0003
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      seed,
    input  logic [15:0]      num_words,
    input  logic [7:0]       ready_pattern,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      word_count,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err_index,
    output logic [WIDTH-1:0] first_err_data,
    output logic [WIDTH-1:0] first_err_expected
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic             r_mode;
    logic [31:0]      r_exp;
    logic [15:0]      r_num;
    logic [7:0]       r_pat;
    logic [15:0]      r_word_count;
    logic [15:0]      r_err_count;
    logic [15:0]      r_first_idx;
    logic [WIDTH-1:0] r_first_data;
    logic [WIDTH-1:0] r_first_exp;
    logic             r_pass;

    logic             w_accept;
    logic             w_mismatch;
    logic [15:0]      w_wc_inc;
    logic [31:0]      w_exp_next;

    assign w_accept   = (r_state == S_RUN) && r_pat[0] && i_tvalid;
    assign w_mismatch = (i_tdata != r_exp[WIDTH-1:0]);
    assign w_wc_inc   = r_word_count + 16'd1;
    assign w_exp_next = r_mode ? ({1'b0, r_exp[31:1]} ^ (r_exp[0] ? LFSR_TAPS : 32'h0))
                               : (r_exp + 32'd1);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (num_words == 16'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept && (w_wc_inc == r_num)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        i_tready = (r_state == S_RUN) && r_pat[0];
        busy     = (r_state == S_RUN);
        done     = (r_state == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_mode       <= 1'b0;
            r_exp        <= 32'h0;
            r_num        <= 16'h0;
            r_pat        <= 8'h0;
            r_word_count <= 16'h0;
            r_err_count  <= 16'h0;
            r_first_idx  <= 16'h0;
            r_first_data <= '0;
            r_first_exp  <= '0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_word_count <= 16'h0;
                        r_err_count  <= 16'h0;
                        if (num_words == 16'd0) begin
                            r_pass <= 1'b1;
                        end else begin
                            r_pass       <= 1'b0;
                            r_first_idx  <= 16'h0;
                            r_first_data <= '0;
                            r_first_exp  <= '0;
                            r_mode       <= mode;
                            r_num        <= num_words;
                            // An all-zero LFSR state would lock up; all-zero pattern would never accept.
                            r_exp        <= (mode && (seed == 32'h0)) ? 32'h1 : seed;
                            r_pat        <= (ready_pattern == 8'h00) ? 8'hFF : ready_pattern;
                        end
                    end
                end
                S_RUN: begin
                    r_pat <= {r_pat[0], r_pat[7:1]};
                    if (w_accept) begin
                        r_word_count <= w_wc_inc;
                        r_exp        <= w_exp_next;
                        if (w_mismatch) begin
                            if (r_err_count != 16'hFFFF) begin
                                r_err_count <= r_err_count + 16'd1;
                            end
                            if (r_err_count == 16'h0) begin
                                r_first_idx  <= r_word_count;
                                r_first_data <= i_tdata;
                                r_first_exp  <= r_exp[WIDTH-1:0];
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_pass <= (r_err_count == 16'h0);
                end
                default: begin
                    r_pass <= r_pass;
                end
            endcase
        end
    end

    assign pass               = r_pass;
    assign word_count         = r_word_count;
    assign err_count          = r_err_count;
    assign first_err_index    = r_first_idx;
    assign first_err_data     = r_first_data;
    assign first_err_expected = r_first_exp;

endmodule

// File: tb/tb_stream_pattern_checker.sv
// Bench for stream_pattern_checker: directed scenarios plus randomized runs against a word-list reference model.
module tb_stream_pattern_checker;

    localparam int          W    = 32;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic          mode  = 1'b0;
    logic [31:0]   seed  = 32'h0;
    logic [15:0]   num_words = 16'h0;
    logic [7:0]    ready_pattern = 8'h0;
    logic [W-1:0]  i_tdata = '0;
    logic          i_tvalid = 1'b0;
    logic          i_tready;
    logic          busy;
    logic          done;
    logic          pass;
    logic [15:0]   word_count;
    logic [15:0]   err_count;
    logic [15:0]   first_err_index;
    logic [W-1:0]  first_err_data;
    logic [W-1:0]  first_err_expected;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   src_q[$];

    always #5 clock = ~clock;

    stream_pattern_checker #(.WIDTH(W), .LFSR_TAPS(TAPS)) dut (
        .clock              (clock),
        .reset              (reset),
        .clear              (clear),
        .start              (start),
        .mode               (mode),
        .seed               (seed),
        .num_words          (num_words),
        .ready_pattern      (ready_pattern),
        .i_tdata            (i_tdata),
        .i_tvalid           (i_tvalid),
        .i_tready           (i_tready),
        .busy               (busy),
        .done               (done),
        .pass               (pass),
        .word_count         (word_count),
        .err_count          (err_count),
        .first_err_index    (first_err_index),
        .first_err_data     (first_err_data),
        .first_err_expected (first_err_expected)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // k-th word of the expected sequence, stepped from the start value by the sequence rule
    function automatic logic [31:0] model_exp(input logic m, input logic [31:0] s, input int k);
        logic [31:0] x;
        x = (m && (s == 32'h0)) ? 32'h1 : s;
        for (int i = 0; i < k; i++) begin
            x = m ? ((x >> 1) ^ (x[0] ? TAPS : 32'h0)) : (x + 32'h1);
        end
        return x;
    endfunction

    task automatic fill_model(input logic m, input logic [31:0] s, input int n);
        src_q.delete();
        for (int k = 0; k < n; k++) src_q.push_back(model_exp(m, s, k));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tready"}, 32'(i_tready), 32'h0);
        check({tag, "_busy"},   32'(busy), 32'h0);
        check({tag, "_done"},   32'(done), 32'h0);
        check({tag, "_pass"},   32'(pass), 32'h0);
        check({tag, "_wc"},     32'(word_count), 32'h0);
        check({tag, "_errs"},   32'(err_count), 32'h0);
        check({tag, "_fidx"},   32'(first_err_index), 32'h0);
        check({tag, "_fdata"},  32'(first_err_data), 32'h0);
        check({tag, "_fexp"},   32'(first_err_expected), 32'h0);
    endtask

    // One full run: sends src_q words, checks ready per cycle, done timing and final report.
    task automatic do_run(input logic m, input logic [31:0] s, input int nw, input logic [7:0] pat,
                          input int vpct, input bit poke, output int busy_cycles);
        logic [7:0]  pe;
        logic [31:0] fdat, fexp, e;
        int          acc, cyc, errs, fidx;
        bit          rdy, vld;
        pe   = (pat == 8'h00) ? 8'hFF : pat;
        errs = 0; fidx = 0; fdat = 0; fexp = 0;
        for (int k = 0; k < nw; k++) begin
            e = model_exp(m, s, k);
            if (src_q[k] !== e) begin
                if (errs == 0) begin
                    fidx = k; fdat = src_q[k]; fexp = e;
                end
                errs++;
            end
        end
        @(negedge clock);
        start = 1'b1; mode = m; seed = s; num_words = 16'(nw); ready_pattern = pat;
        @(negedge clock);
        start = 1'b0;
        acc = 0; cyc = 0; busy_cycles = 0;
        while (acc < nw && cyc < 3000) begin
            rdy = pe[3'(cyc % 8)];
            check("ready_run", 32'(i_tready), 32'(rdy));
            check("busy_run", 32'(busy), 32'h1);
            if (busy) busy_cycles++;
            vld      = ($urandom_range(99) < vpct);
            i_tvalid = vld;
            i_tdata  = vld ? src_q[acc] : $urandom;
            if (poke && cyc == 2) begin
                start = 1'b1; num_words = 16'h1; seed = $urandom; mode = ~m; ready_pattern = 8'h02;
            end else begin
                start = 1'b0;
            end
            if (vld && rdy) acc++;
            cyc++;
            @(negedge clock);
        end
        i_tvalid = 1'b0;
        start    = 1'b0;
        if (cyc >= 3000) begin
            check("run_timeout", 32'(word_count), 32'(nw));
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
        end else begin
            check("done_pulse", 32'(done), 32'h1);
            check("busy_done", 32'(busy), 32'h0);
            check("ready_done", 32'(i_tready), 32'h0);
            check("wc_done", 32'(word_count), 32'(nw));
            @(negedge clock);
            check("done_single", 32'(done), 32'h0);
            check("ready_idle", 32'(i_tready), 32'h0);
            check("pass", 32'(pass), 32'(errs == 0));
            check("err_count", 32'(err_count), 32'(errs));
            check("word_count", 32'(word_count), 32'(nw));
            if (nw > 0) begin
                check("first_idx", 32'(first_err_index), 32'(fidx));
                check("first_data", 32'(first_err_data), fdat);
                check("first_exp", 32'(first_err_expected), fexp);
            end
        end
    endtask

    initial begin
        int bc;
        logic        rm;
        logic [31:0] rs, e;
        logic [7:0]  rp;
        int          rn;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_zero("reset");

        // incrementing counter, full throughput
        src_q = '{32'h10, 32'h11, 32'h12, 32'h13};
        do_run(1'b0, 32'h10, 4, 8'hFF, 100, 1'b0, bc);
        check("cnt_busy_cycles", 32'(bc), 32'd4);

        // single corrupted word
        src_q = '{32'h0, 32'h1, 32'hDEAD_BEEF, 32'h3};
        do_run(1'b0, 32'h0, 4, 8'hFF, 100, 1'b0, bc);
        check("single_err_data", 32'(first_err_data), 32'hDEAD_BEEF);

        // zero-length run after a failing run: pass must come back
        src_q.delete();
        do_run(1'b0, 32'h0, 0, 8'hFF, 100, 1'b0, bc);

        // sparse ready pattern
        fill_model(1'b0, 32'h5, 3);
        do_run(1'b0, 32'h5, 3, 8'b0000_0101, 100, 1'b0, bc);
        check("bp_busy_cycles", 32'(bc), 32'd9);

        // LFSR from zero seed, literal sequence
        src_q = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002};
        do_run(1'b1, 32'h0, 3, 8'hFF, 100, 1'b0, bc);

        // zero pattern behaves as all-ones
        fill_model(1'b1, 32'h1234_5678, 5);
        do_run(1'b1, 32'h1234_5678, 5, 8'h00, 100, 1'b0, bc);

        // start pulse during RUN must be ignored
        fill_model(1'b0, 32'h100, 6);
        do_run(1'b0, 32'h100, 6, 8'hFF, 100, 1'b1, bc);

        // clear mid-run
        @(negedge clock);
        start = 1'b1; mode = 1'b0; seed = 32'h40; num_words = 16'd8; ready_pattern = 8'hFF;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_tvalid = 1'b1;
            i_tdata  = 32'h40 + 32'(k);
            @(negedge clock);
        end
        check("clr_wc_before", 32'(word_count), 32'd3);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check_zero("clear");
        @(negedge clock);
        i_tvalid = 1'b0;
        check("clr_no_done", 32'(done), 32'h0);
        check("clr_stay_idle", 32'(busy), 32'h0);
        fill_model(1'b0, 32'h40, 8);
        do_run(1'b0, 32'h40, 8, 8'hFF, 100, 1'b0, bc);

        // reset mid-run with errors already captured
        @(negedge clock);
        start = 1'b1; mode = 1'b0; seed = 32'h77; num_words = 16'd8; ready_pattern = 8'hFF;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_tvalid = 1'b1;
            i_tdata  = ~(32'h77 + 32'(k));
            @(negedge clock);
        end
        i_tvalid = 1'b0;
        check("rst_errs_before", 32'(err_count), 32'd2);
        check("rst_fdata_before", 32'(first_err_data), ~32'h77);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_zero("reset_mid");

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            rm = 1'($urandom_range(1));
            rs = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
            rn = $urandom_range(24, 1);
            rp = ($urandom_range(4) == 0) ? 8'h00 : 8'($urandom);
            src_q.delete();
            for (int k = 0; k < rn; k++) begin
                e = model_exp(rm, rs, k);
                if ($urandom_range(9) == 0) e = e ^ (32'h1 << $urandom_range(31));
                src_q.push_back(e);
            end
            do_run(rm, rs, rn, rp, $urandom_range(100, 50), 1'b0, bc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
